decoder_2to4: RTL and testbench



---
 rtl/decoder_pkg.sv | 21 ++
 rtl/decoder2_4_comb.sv | 29 ++
 rtl/decoder_2to4.sv | 49 ++++
 tb/tb_decoder_2to4.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared widths, one-hot type and constants for the 2-to-4 decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    localparam int SEL_W = 2;
    localparam int OUT_W = 4;

    typedef logic [OUT_W-1:0] onehot4_t;

    localparam onehot4_t ONEHOT_NONE = '0;
    localparam onehot4_t ONEHOT_SEL0 = 4'b0001;
    localparam onehot4_t ONEHOT_SEL1 = 4'b0010;
    localparam onehot4_t ONEHOT_SEL2 = 4'b0100;
    localparam onehot4_t ONEHOT_SEL3 = 4'b1000;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decoder2_4_comb.sv
`default_nettype none
// ============================================================================
// Module      : decoder2_4_comb
// Description : Combinational 2-to-4 one-hot decode with enable; unknowns decode to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder2_4_comb
    import decoder_pkg::*;
(
    input  logic     A,
    input  logic     B,
    input  logic     en,
    output onehot4_t dec
);

    // Any X/Z on en/A/B matches no item, so the default forces all zeros.
    always_comb begin
        dec = ONEHOT_NONE;
        case ({en, A, B})
            3'b100:  dec = ONEHOT_SEL0;
            3'b101:  dec = ONEHOT_SEL1;
            3'b110:  dec = ONEHOT_SEL2;
            3'b111:  dec = ONEHOT_SEL3;
            default: dec = ONEHOT_NONE;
        endcase
    end

endmodule : decoder2_4_comb
`default_nettype wire

// File: rtl/decoder_2to4.sv
`default_nettype none
// ============================================================================
// Module      : decoder_2to4
// Description : Registered 2-to-4 one-hot decoder with enable and async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_2to4
    import decoder_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     A,
    input  logic     B,
    input  logic     en,
    output onehot4_t y
);

    onehot4_t dec_next;

    decoder2_4_comb u_decode (
        .A   (A),
        .B   (B),
        .en  (en),
        .dec (dec_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= ONEHOT_NONE;
        end else begin
            y <= dec_next;
        end
    end

`ifndef SYNTHESIS
    a_onehot0: assert property (@(posedge clk) $onehot0(y));

    a_reset_zero: assert property (@(posedge clk) !rst_n |-> (y == ONEHOT_NONE));

    a_inputs_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({A, B, en}));

    // Vacuous on the first edge after release, where y was still held in reset.
    a_latency: assert property (@(posedge clk) disable iff (!rst_n)
        $past(rst_n) |-> (y == $past(dec_next)));
`endif

endmodule : decoder_2to4
`default_nettype wire

// File: tb/tb_decoder_2to4.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_2to4
// Description : Directed self-checking bench for the registered 2-to-4 decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_2to4;

    logic       clk;
    logic       rst_n;
    logic       A;
    logic       B;
    logic       en;
    logic [3:0] y;

    int checks;
    int errors;

    decoder_2to4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .en    (en),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; y is sampled 1 time unit after the rising edge.
    task automatic apply(input logic e, input logic a, input logic b);
        @(negedge clk);
        en = e;
        A  = a;
        B  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1; A = 1'b1; B = 1'b1;
        #1;
        checks++;
        if (y !== 4'b0000) begin
            errors++;
            $display("FAIL reset_initial: y=%b expected=%b", y, 4'b0000);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (y !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: y=%b expected=%b", i, y, 4'b0000);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (y !== 4'b1000) begin
            errors++;
            $display("FAIL reset_release: y=%b expected=%b", y, 4'b1000);
        end
    endtask

    task automatic test_enabled_sweep();
        logic [3:0] exp_tab [4];
        exp_tab[0] = 4'b0001;
        exp_tab[1] = 4'b0010;
        exp_tab[2] = 4'b0100;
        exp_tab[3] = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] s;
            s = 2'(i);
            apply(1'b1, s[1], s[0]);
            checks++;
            if (y !== exp_tab[i]) begin
                errors++;
                $display("FAIL enabled_sel%0d: y=%b expected=%b", i, y, exp_tab[i]);
            end
        end
    endtask

    task automatic test_disabled_sweep();
        for (int i = 0; i < 4; i++) begin
            logic [1:0] s;
            s = 2'(i);
            apply(1'b0, s[1], s[0]);
            checks++;
            if (y !== 4'b0000) begin
                errors++;
                $display("FAIL disabled_sel%0d: y=%b expected=%b", i, y, 4'b0000);
            end
        end
    endtask

    task automatic test_enable_toggle();
        logic       en_seq  [3];
        logic [3:0] exp_seq [3];
        en_seq[0] = 1'b1; exp_seq[0] = 4'b0100;
        en_seq[1] = 1'b0; exp_seq[1] = 4'b0000;
        en_seq[2] = 1'b1; exp_seq[2] = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            apply(en_seq[i], 1'b1, 1'b0);
            checks++;
            if (y !== exp_seq[i]) begin
                errors++;
                $display("FAIL enable_toggle[%0d]: y=%b expected=%b", i, y, exp_seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply(1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b1);
        checks++;
        if (y !== 4'b1000) begin
            errors++;
            $display("FAIL same_edge_en_sel: y=%b expected=%b", y, 4'b1000);
        end
        apply(1'b1, 1'b0, 1'b1);
        checks++;
        if (y !== 4'b0010) begin
            errors++;
            $display("FAIL sel_11_to_01: y=%b expected=%b", y, 4'b0010);
        end
    endtask

    task automatic test_async_reset();
        apply(1'b1, 1'b0, 1'b1);
        checks++;
        if (y !== 4'b0010) begin
            errors++;
            $display("FAIL async_pre: y=%b expected=%b", y, 4'b0010);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y !== 4'b0000) begin
            errors++;
            $display("FAIL async_assert: y=%b expected=%b", y, 4'b0000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (y !== 4'b0000) begin
            errors++;
            $display("FAIL async_hold: y=%b expected=%b", y, 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (y !== 4'b0010) begin
            errors++;
            $display("FAIL async_resume: y=%b expected=%b", y, 4'b0010);
        end
    endtask

    task automatic test_glitch();
        apply(1'b1, 1'b0, 1'b0);
        checks++;
        if (y !== 4'b0001) begin
            errors++;
            $display("FAIL glitch_pre: y=%b expected=%b", y, 4'b0001);
        end
        @(negedge clk);
        A = 1'b1;
        #2;
        checks++;
        if (y !== 4'b0001) begin
            errors++;
            $display("FAIL glitch_mid: y=%b expected=%b", y, 4'b0001);
        end
        A = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (y !== 4'b0001) begin
            errors++;
            $display("FAIL glitch_post: y=%b expected=%b", y, 4'b0001);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_enabled_sweep();
        test_disabled_sweep();
        test_enable_toggle();
        test_back_to_back();
        test_async_reset();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_decoder_2to4
`default_nettype wire
